// File: rtl/srm_ctrl_if.sv
// Control bundle between the SRM control FSM and the IR/datapath/RAM side.
// The master side is the FSM: it reads the IR fields and drives every control.
interface srm_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       opcode;
    logic [1:0]       op;
    logic [1:0]       reg_sel;
    logic             w_en;
    logic [1:0]       wb_sel;
    logic             en_A;
    logic             en_B;
    logic             en_C;
    logic             en_status;
    logic             sel_A;
    logic             sel_B;
    logic             sh_en;
    logic             load_ir;
    logic             load_pc;
    logic             clear_pc;
    logic             load_addr;
    logic             sel_addr;
    logic [1:0]       mem_cmd;
    logic             halted;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        input  opcode, op,
        output reg_sel, w_en, wb_sel, en_A, en_B, en_C, en_status, sel_A, sel_B, sh_en,
               load_ir, load_pc, clear_pc, load_addr, sel_addr, mem_cmd, halted, retire,
               retire_cnt
    );

    modport slave (
        output opcode, op,
        input  reg_sel, w_en, wb_sel, en_A, en_B, en_C, en_status, sel_A, sel_B, sh_en,
               load_ir, load_pc, clear_pc, load_addr, sel_addr, mem_cmd, halted, retire,
               retire_cnt
    );
endinterface

// File: rtl/srm_ctrl_fsm.sv
// Simple RISC Machine control FSM: fetch / PC update / decode / execute sequencing.
// Moore machine: every control output is a function of the state register (and the
// RAM-latency sub-counter, which is part of that state). IR fields only steer transitions;
// the IR is stable for the whole decode/execute sequence.
module srm_ctrl_fsm #(
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    srm_ctrl_if.master    bus
);
    typedef enum logic [4:0] {
        S_RESET, S_IF, S_UPD_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_GET_C, S_WR_REG,
        S_GET_STAT, S_GET_ADR, S_LD_ADR, S_MRD, S_GET_BD, S_GET_CP, S_MWR, S_HALT
    } state_t;

    localparam int            LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

    localparam logic [4:0] I_MOVI = 5'b110_10;
    localparam logic [4:0] I_MOVR = 5'b110_00;
    localparam logic [4:0] I_MVN  = 5'b101_11;
    localparam logic [4:0] I_ADD  = 5'b101_00;
    localparam logic [4:0] I_AND  = 5'b101_10;
    localparam logic [4:0] I_CMP  = 5'b101_01;
    localparam logic [4:0] I_LDR  = 5'b011_00;
    localparam logic [4:0] I_STR  = 5'b100_00;

    state_t           state;
    state_t           state_n;
    logic [LW-1:0]    lat_cnt;
    logic             lat_last;
    logic [4:0]       instr;
    logic             retire;
    logic [CNT_W-1:0] cnt_q;

    assign instr    = {bus.opcode, bus.op};
    assign lat_last = (lat_cnt == LAT_LAST);

    // State register plus the cycle counter for multi-cycle RAM reads (restarts on every state change).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RESET;
            lat_cnt <= '0;
        end else begin
            state   <= state_n;
            lat_cnt <= (state_n != state) ? '0 : lat_cnt + 1'b1;
        end
    end

    // Next-state: fetch pipeline, decode dispatch, then per-instruction execute chains.
    always_comb begin
        state_n = state;
        case (state)
            S_RESET:  state_n = S_IF;
            S_IF:     if (lat_last) state_n = S_UPD_PC;
            S_UPD_PC: state_n = S_DECODE;
            S_DECODE: begin
                case (instr)
                    I_MOVI:                              state_n = S_WR_IMM;
                    I_MOVR, I_MVN:                       state_n = S_GET_B;
                    I_ADD, I_AND, I_CMP, I_LDR, I_STR:   state_n = S_GET_A;
                    default:                             state_n = S_HALT;
                endcase
            end
            S_GET_A:    state_n = (bus.opcode == 3'b101) ? S_GET_B : S_GET_ADR;
            S_GET_B:    state_n = (instr == I_CMP) ? S_GET_STAT : S_GET_C;
            S_GET_C:    state_n = S_WR_REG;
            S_GET_ADR:  state_n = S_LD_ADR;
            S_LD_ADR:   state_n = (bus.opcode == 3'b011) ? S_MRD : S_GET_BD;
            S_MRD:      if (lat_last) state_n = S_IF;
            S_GET_BD:   state_n = S_GET_CP;
            S_GET_CP:   state_n = S_MWR;
            S_WR_IMM, S_WR_REG, S_GET_STAT, S_MWR: state_n = S_IF;
            S_HALT:     state_n = S_HALT;
            default:    state_n = S_RESET;
        endcase
    end

    // Moore output decode; everything not named in a state stays deasserted.
    always_comb begin
        bus.reg_sel   = 2'd0;
        bus.w_en      = 1'b0;
        bus.wb_sel    = 2'd0;
        bus.en_A      = 1'b0;
        bus.en_B      = 1'b0;
        bus.en_C      = 1'b0;
        bus.en_status = 1'b0;
        bus.sel_A     = 1'b0;
        bus.sel_B     = 1'b0;
        bus.sh_en     = 1'b0;
        bus.load_ir   = 1'b0;
        bus.load_pc   = 1'b0;
        bus.clear_pc  = 1'b0;
        bus.load_addr = 1'b0;
        bus.sel_addr  = 1'b0;
        bus.mem_cmd   = 2'b00;
        bus.halted    = 1'b0;
        retire        = 1'b0;
        case (state)
            S_RESET: begin
                bus.load_pc  = 1'b1;
                bus.clear_pc = 1'b1;
            end
            S_IF: begin
                bus.sel_addr = 1'b1;
                bus.mem_cmd  = 2'b01;
                bus.load_ir  = lat_last;
            end
            S_UPD_PC: bus.load_pc = 1'b1;
            S_WR_IMM: begin
                bus.wb_sel = 2'd1;
                bus.w_en   = 1'b1;
                retire     = 1'b1;
            end
            S_GET_A: begin
                bus.reg_sel = 2'd0;
                bus.en_A    = 1'b1;
            end
            S_GET_B: begin
                bus.reg_sel = 2'd2;
                bus.en_B    = 1'b1;
                bus.sh_en   = 1'b1;
            end
            S_GET_C: bus.en_C = 1'b1;
            S_WR_REG: begin
                bus.reg_sel = 2'd1;
                bus.wb_sel  = 2'd0;
                bus.w_en    = 1'b1;
                retire      = 1'b1;
            end
            S_GET_STAT: begin
                bus.en_status = 1'b1;
                retire        = 1'b1;
            end
            S_GET_ADR: begin
                bus.sel_B = 1'b1;
                bus.en_C  = 1'b1;
            end
            S_LD_ADR: bus.load_addr = 1'b1;
            S_MRD: begin
                bus.mem_cmd = 2'b01;
                if (lat_last) begin
                    bus.w_en    = 1'b1;
                    bus.reg_sel = 2'd1;
                    bus.wb_sel  = 2'd2;
                    retire      = 1'b1;
                end
            end
            S_GET_BD: begin
                bus.reg_sel = 2'd1;
                bus.en_B    = 1'b1;
            end
            S_GET_CP: begin
                bus.sel_A = 1'b1;
                bus.en_C  = 1'b1;
            end
            S_MWR: begin
                bus.mem_cmd = 2'b10;
                retire      = 1'b1;
            end
            S_HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end

    // Retired-instruction counter; bumps on the edge that leaves a retiring state, wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + 1'b1;
    end

    assign bus.retire     = retire;
    assign bus.retire_cnt = cnt_q;
endmodule
